serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl.sv | 149 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder sequencer built around a
// single openlane_full_adder cell. One operand bit per clock, LSB first,
// with the running carry held in a flop between cycles.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a 'sub' input that turns
// the operation into op_a - op_b (two's complement: ~op_b plus carry 1).

module openlane_full_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);
  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             carry_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             fa_s, fa_c;

  // Operand B and initial carry as latched on accept; subtract inverts B and
  // forces the carry so the cell computes a + ~b + 1.
  logic [WIDTH-1:0] b_load;
  logic             cy_load;
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load  = sub ? ~op_b : op_b;
  assign cy_load = sub ? 1'b1  : carry_in;
`else
  assign b_load  = op_b;
  assign cy_load = carry_in;
`endif

  openlane_full_adder u_fa (
    .a         (a_q[0]),
    .b         (b_q[0]),
    .carry_in  (cy_q),
    .sum       (fa_s),
    .carry_out (fa_c)
  );

  // Handshake/status outputs decode straight from state; in_ready is masked
  // by rst so nothing can be accepted while reset is held.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign carry_out = cout_q;

  // Next-state and datapath: load on accept, shift one bit per RUN cycle,
  // publish the result register only on the final bit so sum/carry_out keep
  // the previous result while a new operation is in flight.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = op_a;
          b_d     = b_load;
          cy_d    = cy_load;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        cy_d  = fa_c;
        sh_d  = {fa_s, sh_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          sum_d   = {fa_s, sh_q[WIDTH-1:1]};
          cout_d  = fa_c;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized + directed bench for serial_adder_ctrl (WIDTH=8). Expected
// results come from plain integer arithmetic on the operands.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         carry_in = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         busy;

  int n_vec = 0;
  int n_bad = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .carry_in  (carry_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, wait for the result, optional backpressure
  // (with a pending request held on the input if pend), then release.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sb, input bit tog, input int bp, input bit pend);
    logic [W:0]   exp;
    logic [W-1:0] nb;
    logic [W-1:0] hs;
    logic         hc;
    int           k;
    bit           seen;
    nb = ~b;
    if (sb) exp = {1'b0, a} + {1'b0, nb} + (W+1)'(1);
    else    exp = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    k = 0;
    while (!in_ready && k < 20) begin @(posedge clk); #1; k++; end
    chk("in_ready_idle", 64'(in_ready), 64'(1));
    op_a = a; op_b = b; carry_in = cin; sub = sb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 0;
    for (k = 1; k <= W + 4; k++) begin
      if (tog) begin op_a = W'($urandom); op_b = W'($urandom); carry_in = 1'($urandom); sub = 1'($urandom); end
      @(posedge clk); #1;
      if (out_valid) begin seen = 1; break; end
      if (k == 2) chk("in_ready_run", 64'(in_ready), 64'(0));
    end
    chk("latency", seen ? 64'(k) : 64'(0), 64'(W));
    chk("sum", 64'(sum), 64'(exp[W-1:0]));
    chk("carry_out", 64'(carry_out), 64'(exp[W]));
    chk("busy_done", 64'(busy), 64'(1));
    hs = sum; hc = carry_out;
    if (pend) begin op_a = 8'h01; op_b = 8'h02; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1; end
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 64'(out_valid), 64'(1));
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_sum", 64'(sum), 64'(hs));
      chk("bp_cout", 64'(carry_out), 64'(hc));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("rel_valid", 64'(out_valid), 64'(0));
    chk("rel_in_ready", 64'(in_ready), 64'(1));
    chk("rel_busy", 64'(busy), 64'(0));
    chk("rel_sum_kept", 64'(sum), 64'(hs));
  endtask

  initial begin
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_sum", 64'(sum), 64'(0));
    chk("rst_cout", 64'(carry_out), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(8'h35, 8'h0A, 1'b0, 1'b0, 0, 0, 0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 0, 0);
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0, 0, 0);
    // backpressure with a pending request; it is accepted right after release
    do_op(8'hA5, 8'h3C, 1'b1, 1'b0, 0, 5, 1);
    do_op(8'h01, 8'h02, 1'b0, 1'b0, 0, 0, 0);

    // reset while counter == 3 in RUN
    op_a = 8'h55; op_b = 8'h66; carry_in = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_sum", 64'(sum), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    do_op(8'h10, 8'h20, 1'b0, 1'b0, 0, 0, 0);

    // operands wiggle throughout RUN
    do_op(8'h5A, 8'hC3, 1'b1, 1'b0, 1, 0, 0);

`ifdef SERIAL_ADDER_SUB_EN
    do_op(8'h10, 8'h01, 1'b0, 1'b1, 0, 0, 0);
    do_op(8'h00, 8'h01, 1'b1, 1'b1, 0, 0, 0);
    do_op(8'h35, 8'h0A, 1'b0, 1'b0, 0, 0, 0);
`endif

    for (int r = 0; r < 30; r++) begin
      logic sb;
`ifdef SERIAL_ADDER_SUB_EN
      sb = 1'($urandom);
`else
      sb = 1'b0;
`endif
      do_op(W'($urandom), W'($urandom), 1'($urandom), sb, bit'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
